// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants and types for the modular arithmetic blocks.
//   DefaultWidth  default operand/modulus width
//   OP_ADD/OP_SUB operation encodings on the op input
//   state_e       mod_add_seq FSM state encoding
package rsa_pkg;

  localparam int unsigned DefaultWidth = 1024;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPass1 = 2'd1,
    StPass2 = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/kogge_stone_adder.sv
// kogge_stone_adder: WIDTH-bit parallel-prefix adder with carry in/out.
//   a_i, b_i  addends
//   ci_i      carry in
//   sum_o     a_i + b_i + ci_i, low WIDTH bits
//   co_o      carry out of bit WIDTH-1
module kogge_stone_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);

  localparam int Levels = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int W      = int'(WIDTH);

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] p_pre;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH:0]   carry;

  always_comb begin
    p0    = a_i ^ b_i;
    g_pre = a_i & b_i;
    p_pre = p0;
    g_nxt = g_pre;
    p_nxt = p_pre;
    // After level l, bit i holds group generate/propagate over bits (i-2^(l+1)+1)..i.
    for (int l = 0; l < Levels; l++) begin
      g_nxt = g_pre;
      p_nxt = p_pre;
      for (int i = (1 << l); i < W; i++) begin
        g_nxt[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
        p_nxt[i] = p_pre[i] & p_pre[i - (1 << l)];
      end
      g_pre = g_nxt;
      p_pre = p_nxt;
    end
    // Carry into bit i+1 is the prefix generate over 0..i, or its propagate with ci_i.
    carry = {g_pre | (p_pre & {WIDTH{ci_i}}), ci_i};
  end

  assign sum_o = p0 ^ carry[WIDTH-1:0];
  assign co_o  = carry[WIDTH];

endmodule

// File: rtl/mod_add_unit.sv
// mod_add_unit: mod_add_seq bundled with its own kogge_stone_adder.
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake with op, a, b, n
//   out_valid/out_ready    result handshake
//   result, busy           as for mod_add_seq
module mod_add_unit
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_ci;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_co;

  mod_add_seq #(
    .WIDTH(WIDTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .n        (n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy),
    .adder_a  (adder_a),
    .adder_b  (adder_b),
    .adder_ci (adder_ci),
    .adder_sum(adder_sum),
    .adder_co (adder_co)
  );

  kogge_stone_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i  (adder_a),
    .b_i  (adder_b),
    .ci_i (adder_ci),
    .sum_o(adder_sum),
    .co_o (adder_co)
  );

endmodule

// File: rtl/mod_add_seq.sv
// mod_add_seq: two-pass modular add/subtract using an external shared adder.
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake; op, a, b, n latched on accept
//   out_valid/out_ready    result handshake; result held while out_valid
//   busy                   request in flight
//   adder_a/b/ci           drive the shared WIDTH-bit adder (zero when idle/done)
//   adder_sum/adder_co     combinational sum and carry from the shared adder
module mod_add_seq
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_ci,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_co
);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             c1_q, c1_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Adder operand steering; kept apart from the next-state block so the
  // path out to the adder and back in does not form a loop inside one process.
  always_comb begin
    adder_a  = '0;
    adder_b  = '0;
    adder_ci = 1'b0;
    unique case (state_q)
      StPass1: begin
        // Subtract as a + ~b + 1.
        adder_a  = a_q;
        adder_b  = (op_q == OP_SUB) ? ~b_q : b_q;
        adder_ci = (op_q == OP_SUB);
      end
      StPass2: begin
        // Add: trial t - n. Subtract: correction t + n.
        adder_a  = t_q;
        adder_b  = (op_q == OP_SUB) ? n_q : ~n_q;
        adder_ci = (op_q == OP_ADD);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    t_d      = t_q;
    c1_d     = c1_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          n_d     = n;
          state_d = StPass1;
        end
      end
      StPass1: begin
        t_d     = adder_sum;
        c1_d    = adder_co;
        state_d = StPass2;
      end
      StPass2: begin
        if (op_q == OP_ADD) begin
          // Wrap when the sum overflowed WIDTH bits or t >= n.
          result_d = (c1_q | adder_co) ? adder_sum : t_q;
        end else begin
          // c1 set means a >= b, so no correction is needed.
          result_d = c1_q ? t_q : adder_sum;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      t_q      <= '0;
      c1_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      t_q      <= t_d;
      c1_q     <= c1_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_mod_add_seq.sv
// tb_mod_add_seq: self-checking bench for mod_add_seq (8-bit, behavioural adder)
// and mod_add_unit (1024-bit, with the prefix adder).
module tb_mod_add_seq;
  import rsa_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned BigW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [W-1:0] a, b, n, result;
  logic [W-1:0] ad_a, ad_b, ad_sum;
  logic         ad_ci, ad_co;

  logic            w_in_valid, w_in_ready, w_op, w_out_valid, w_out_ready, w_busy;
  logic [BigW-1:0] w_a, w_b, w_n, w_result;

  // Reference for the external shared adder.
  assign {ad_co, ad_sum} = {1'b0, ad_a} + {1'b0, ad_b} + {{W{1'b0}}, ad_ci};

  mod_add_seq #(
    .WIDTH(W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .n        (n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy),
    .adder_a  (ad_a),
    .adder_b  (ad_b),
    .adder_ci (ad_ci),
    .adder_sum(ad_sum),
    .adder_co (ad_co)
  );

  mod_add_unit #(
    .WIDTH(BigW)
  ) u_big (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .op       (w_op),
    .a        (w_a),
    .b        (w_b),
    .n        (w_n),
    .out_valid(w_out_valid),
    .out_ready(w_out_ready),
    .result   (w_result),
    .busy     (w_busy)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] exp;
  } vec_t;

  vec_t            vecs[12];
  logic [W-1:0]    exp_q[$];
  logic [BigW-1:0] big_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_big(input string name, input logic [BigW-1:0] act,
                         input logic [BigW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got msb=%0b low64=0x%0h, expected msb=%0b low64=0x%0h",
                  name, act[BigW-1], act[63:0], exp[BigW-1], exp[63:0]);
  endtask

  // One request on the 8-bit DUT; operands are scrambled right after acceptance.
  task automatic run8(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] nv, input logic [W-1:0] expv, input string tag);
    int           lat;
    logic [W-1:0] e;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    op = opv; a = av; b = bv; n = nv; in_valid = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0; op = ~opv; a = W'($urandom); b = W'($urandom); n = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd3);
    e = exp_q.pop_front();
    chk({tag, " result"}, 64'(result), 64'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_big(input logic opv, input logic [BigW-1:0] av,
                         input logic [BigW-1:0] bv, input logic [BigW-1:0] nv,
                         input logic [BigW-1:0] expv, input string tag);
    int lat;
    @(negedge clk);
    w_op = opv; w_a = av; w_b = bv; w_n = nv; w_in_valid = 1'b1;
    big_q.push_back(expv);
    @(negedge clk);
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_n = '1;
    lat = 1;
    while (!w_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd3);
    chk_big({tag, " result"}, w_result, big_q.pop_front());
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BigW-1:0] big_n;
    logic            stable;

    vecs[0]  = '{OP_ADD, 8'd7,   8'd9,   8'd13,  8'd3};
    vecs[1]  = '{OP_ADD, 8'd200, 8'd100, 8'd251, 8'd49};
    vecs[2]  = '{OP_ADD, 8'd5,   8'd3,   8'd13,  8'd8};
    vecs[3]  = '{OP_SUB, 8'd3,   8'd9,   8'd13,  8'd7};
    vecs[4]  = '{OP_SUB, 8'd5,   8'd5,   8'd13,  8'd0};
    vecs[5]  = '{OP_SUB, 8'd9,   8'd3,   8'd13,  8'd6};
    vecs[6]  = '{OP_ADD, 8'd12,  8'd12,  8'd13,  8'd11};
    vecs[7]  = '{OP_SUB, 8'd0,   8'd12,  8'd13,  8'd1};
    vecs[8]  = '{OP_ADD, 8'd0,   8'd0,   8'd1,   8'd0};
    vecs[9]  = '{OP_SUB, 8'd250, 8'd0,   8'd251, 8'd250};
    // Out of contract (a >= n): selection rules still apply.
    vecs[10] = '{OP_ADD, 8'd20,  8'd3,   8'd13,  8'd10};
    vecs[11] = '{OP_SUB, 8'd20,  8'd3,   8'd13,  8'd17};

    rst = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'd5; b = 8'd3; n = 8'd13;
    out_ready = 1'b0;
    w_in_valid = 1'b1; w_op = OP_ADD; w_a = '0; w_b = '0; w_n = '1; w_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy while reset with in_valid", 64'(busy), 64'd0);
    rst = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("idle adder inputs", {ad_ci, 47'd0, ad_a, ad_b}, 64'd0);
    repeat (3) @(negedge clk);
    chk("no accept during reset", {62'd0, busy, w_busy}, 64'd0);

    foreach (vecs[i]) begin
      run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // V4: back-pressure in DONE, in_valid pulses ignored throughout.
    @(negedge clk);
    op = OP_SUB; a = 8'd3; b = 8'd9; n = 8'd13; in_valid = 1'b1;
    exp_q.push_back(8'd7);
    @(negedge clk);
    op = OP_ADD; a = 8'd1; b = 8'd1; n = 8'd3;
    chk("v4 in_ready in pass1", 64'(in_ready), 64'd0);
    chk("v4 busy in pass1", 64'(busy), 64'd1);
    @(negedge clk);
    chk("v4 pass2 adder_ci", 64'(ad_ci), 64'd0);
    @(negedge clk);
    chk("v4 out_valid", 64'(out_valid), 64'd1);
    chk("v4 result", 64'(result), 64'(exp_q.pop_front()));
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 8'd7 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("v4 held stable under back-pressure", 64'(stable), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("v4 in_ready after handshake", 64'(in_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("v4 pulses not queued", {62'd0, busy, out_valid}, 64'd0);

    // V5: reset in PASS2 discards the in-flight result.
    @(negedge clk);
    op = OP_ADD; a = 8'd7; b = 8'd9; n = 8'd13; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("v5 in pass2", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("v5 out_valid", 64'(out_valid), 64'd0);
    chk("v5 busy", 64'(busy), 64'd0);
    chk("v5 result", 64'(result), 64'd0);
    chk("v5 in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("v5 result discarded", 64'(out_valid), 64'd0);
    run8(OP_ADD, 8'd200, 8'd100, 8'd251, 8'd49, "v5 next");

    // V6: 1024-bit corner cases with n = 2^1023 + 1.
    big_n = '0;
    big_n[BigW-1] = 1'b1;
    big_n[0] = 1'b1;
    run_big(OP_ADD, big_n - 1, {{(BigW-1){1'b0}}, 1'b1}, big_n, '0, "v6 add");
    run_big(OP_SUB, '0, {{(BigW-1){1'b0}}, 1'b1}, big_n, big_n - 1, "v6 sub");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_add_seq.md
MOD_ADD_SEQ -- requirements
Module: mod_add_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 1024, operand/modulus width in bits.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning); clk and rst SHALL be the only clock and reset.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  1  0 = modular add, 1 = modular subtract.
- a  in  WIDTH  operand A, contract a < n.
- b  in  WIDTH  operand B, contract b < n.
- n  in  WIDTH  modulus, contract n > 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  (a+b) mod n or (a-b) mod n.
- busy  out  1  request in flight (not IDLE).
- adder_a  out  WIDTH  to the shared WIDTH-bit carry-in adder.
- adder_b  out  WIDTH  to the shared adder.
- adder_ci  out  1  to the shared adder.
- adder_sum  in  WIDTH  combinational sum from the shared adder.
- adder_co  in  1  combinational carry-out from the shared adder.

Function
REQ-003 The FSM SHALL have the states IDLE, PASS1, PASS2 and DONE.
REQ-004 In IDLE: in_ready=1. If in_valid=1, the block SHALL latch op, a, b and n and go to PASS1.
REQ-005 In PASS1 for op=0, the adder inputs SHALL be (a, b, ci=0); for op=1 they SHALL be (a, ~b, ci=1). The block SHALL register t=adder_sum and c1=adder_co, then go to PASS2.
REQ-006 In PASS2 for op=0, the adder inputs SHALL be (t, ~n, ci=1); for op=1 they SHALL be (t, n, ci=0). Let u=adder_sum and c2=adder_co.
REQ-007 Selection rule for op=0: result SHALL be u if (c1 | c2), else t.
REQ-008 Selection rule for op=1: result SHALL be t if c1, else u.
REQ-009 The selected value SHALL be registered into result at the end of PASS2, and the FSM SHALL go to DONE.
REQ-010 In DONE: out_valid=1, and result SHALL be held stable until out_ready=1. On the handshake the FSM SHALL go to IDLE.
REQ-011 Latency SHALL be fixed with no early exit: out_valid rises 3 cycles after the accept edge. in_ready returns high the cycle after the out_valid & out_ready handshake.
REQ-012 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored and not queued.
REQ-013 Latched operands SHALL be unaffected by input changes after acceptance.
REQ-014 In IDLE and DONE, adder_a, adder_b and adder_ci SHALL be driven to 0.
REQ-015 busy SHALL be 1 in PASS1, PASS2 and DONE.
REQ-016 All arithmetic SHALL be performed exactly WIDTH bits wide, with carries taken only from adder_co. No additional adder SHALL be inferred inside the block.
REQ-017 For out-of-contract operands (a >= n or b >= n), result SHALL still follow REQ-007/REQ-008 exactly, with no error flag.

Reset
REQ-018 When rst=1 at a clock edge, the following SHALL hold in any state, including mid-PASS1/PASS2/DONE:
- state=IDLE, out_valid=0, result=0, busy=0;
- t=0, c1=0, latched operands=0;
- in_ready=1 on the first cycle after rst deasserts.
An in-flight result SHALL be discarded.
REQ-019 An in_valid asserted while rst=1 SHALL NOT be accepted.

Structure
REQ-020 A shared package rsa_pkg SHALL hold the op encodings OP_ADD=1'b0 and OP_SUB=1'b1, the FSM state encoding, and the default WIDTH constant.
REQ-021 The adder SHALL be a separate kogge_stone_adder-class instance connected through the adder_* ports. A thin parent mod_add_unit (mod_add_seq plus adder) SHALL be the natural sub-module boundary; mod_add_seq itself SHALL contain no sub-modules.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (WIDTH=8 unless stated).
- V1: op=0, a=7, b=9, n=13 -> result=3, out_valid exactly 3 cycles after accept.
- V2: op=0, a=200, b=100, n=251 (8-bit carry, c1=1) -> result=49; also op=0, a=5, b=3, n=13 -> 8.
- V3: op=1, a=3, b=9, n=13 -> 7; op=1, a=5, b=5, n=13 -> 0; op=1, a=9, b=3, n=13 -> 6.
- V4: out_ready held low 5 cycles in DONE -> result and out_valid stable; in_valid pulses during the operation are ignored; in_ready high the cycle after the handshake.
- V5: rst asserted during PASS2 -> next cycle out_valid=0, busy=0, result=0, in_ready=1; the following request completes correctly.
- V6: WIDTH=1024, op=0, a=n-1, b=1, n=2^1023+1 -> result=0; op=1, a=0, b=1 -> result=n-1.
